systolic_drain: RTL and testbench

Output collector for a `systolic_vector` column. It captures the skewed per-row results (`feature_out` qualified by `out_in`) into per-row FIFOs and reassembles each complete column vector. It then serializes the vector, row 0 first, onto a single valid/ready stream toward the output buffer. It is the receiving end of the column's result interface.

---
 rtl/systolic_drain_pkg.sv | 18 +
 rtl/systolic_drain_if.sv | 20 ++
 rtl/systolic_drain_fifo.sv | 61 ++++++
 rtl/systolic_drain.sv | 123 ++++++++++++
 tb/tb_systolic_drain.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/systolic_drain_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : sys_pkg                                                         |
// | Brief    : Shared types and default sizes for the systolic column blocks.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package sys_pkg;
    localparam int c_WIDTH = 8;
    localparam int c_ROW   = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;
endpackage

`default_nettype wire

// File: rtl/systolic_drain_if.sv
// +----------------------------------------------------------------------------+
// | Module   : systolic_drain_if                                               |
// | Brief    : Valid/ready element stream from the drain to the output buffer. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface systolic_drain_if #(
    parameter int width = 8
);
    logic [width-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

`default_nettype wire

// File: rtl/systolic_drain_fifo.sv
// +----------------------------------------------------------------------------+
// | Module   : drain_fifo                                                      |
// | Brief    : Single-clock synchronous FIFO; write accepted when full if a    |
// |            pop happens on the same edge.                                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module drain_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [width-1:0]         din,
    output logic      [width-1:0]         dout,
    output logic                          empty,
    output logic                          full,
    output logic      [$clog2(depth):0]   count
);
    localparam int c_AW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [c_AW-1:0]  wptr_q;
    logic [c_AW-1:0]  rptr_q;
    logic [c_AW:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == (c_AW+1)'(depth));
    assign count = count_q;
    assign dout  = mem_q[rptr_q];
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: reads are gated by the count.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= din;
    end
endmodule

`default_nettype wire

// File: rtl/systolic_drain.sv
// +----------------------------------------------------------------------------+
// | Module   : systolic_drain                                                  |
// | Brief    : Collects skewed per-row column results into row FIFOs and       |
// |            streams each complete vector row 0 first. Define                |
// |            SYS_DRAIN_RELU_EN to zero negative elements on the stream side. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module systolic_drain
    import sys_pkg::*;
#(
    parameter int width = c_WIDTH,
    parameter int row   = c_ROW,
    parameter int depth = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [width-1:0]     feature_out [row-1:0],
    input  wire logic [row-1:0]       out_in,
    systolic_drain_if.master          m_if,
    output logic                      overflow,
    output logic                      busy
);
    localparam int              c_IW   = $clog2(row);
    localparam int              c_CW   = $clog2(depth) + 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(row - 1);

    drain_state_t     state_q, state_d;
    logic [c_IW-1:0]  idx_q, idx_d;
    logic             overflow_q, overflow_d;

    logic [width-1:0] head [row];
    logic [c_CW-1:0]  count [row];
    logic [row-1:0]   empty;
    logic [row-1:0]   full;
    logic [row-1:0]   keep;
    logic [row-1:0]   drop;
    logic [width-1:0] head_sel;
    logic             stream;
    logic             xfer;
    logic             pop_all;

    assign stream  = (state_q == STREAM);
    assign xfer    = stream & m_if.m_ready;
    assign pop_all = xfer & (idx_q == c_LAST);

    generate
        for (genvar i = 0; i < row; i++) begin : g_row
            drain_fifo #(
                .width (width),
                .depth (depth)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (out_in[i]),
                .pop   (pop_all),
                .din   (feature_out[i]),
                .dout  (head[i]),
                .empty (empty[i]),
                .full  (full[i]),
                .count (count[i])
            );
            // Row still holds a vector after the pop if it had two or is refilled now.
            assign keep[i] = (count[i] > c_CW'(1)) | out_in[i];
            assign drop[i] = out_in[i] & full[i] & ~pop_all;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        overflow_d = overflow_q | (|drop);
        case (state_q)
            IDLE: begin
                if (&(~empty)) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (idx_q == c_LAST) begin
                        idx_d   = '0;
                        state_d = (&keep) ? STREAM : IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_sel     = head[idx_q];
        m_if.m_valid = stream;
        m_if.m_last  = stream & (idx_q == c_LAST);
        m_if.m_data  = '0;
`ifdef SYS_DRAIN_RELU_EN
        if (stream && !head_sel[width-1]) m_if.m_data = head_sel;
`else
        if (stream) m_if.m_data = head_sel;
`endif
    end

    assign overflow = overflow_q;
    assign busy     = stream | ~(&empty);
endmodule

`default_nettype wire

// File: tb/tb_systolic_drain.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_systolic_drain                                               |
// | Brief    : Directed scoreboard bench for systolic_drain.                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_systolic_drain;
    localparam int W = 8;
    localparam int R = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] feature_out [R-1:0];
    logic [R-1:0] out_in;
    logic         overflow;
    logic         busy;

    int           total   = 0;
    int           bad     = 0;
    int           emitted = 0;
    logic [W:0]   exp_q [$];

    systolic_drain_if #(.width(W)) sif ();

    systolic_drain #(
        .width (W),
        .row   (R),
        .depth (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .feature_out (feature_out),
        .out_in      (out_in),
        .m_if        (sif),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [W-1:0] f_stream(input logic [W-1:0] v);
`ifdef SYS_DRAIN_RELU_EN
        return v[W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one capture cycle; optionally record the resulting vector as expected.
    task automatic cap(input logic [R-1:0] mask, input logic [W-1:0] v0, input logic [W-1:0] v1,
                       input logic [W-1:0] v2, input logic [W-1:0] v3, input bit expect_out);
        feature_out[0] = v0;
        feature_out[1] = v1;
        feature_out[2] = v2;
        feature_out[3] = v3;
        out_in         = mask;
        if (expect_out) begin
            exp_q.push_back({1'b0, f_stream(v0)});
            exp_q.push_back({1'b0, f_stream(v1)});
            exp_q.push_back({1'b0, f_stream(v2)});
            exp_q.push_back({1'b1, f_stream(v3)});
        end
        tick();
        out_in = '0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk("idle_busy", busy, 0);
        chk("idle_valid", sif.m_valid, 0);
    endtask

    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst && sif.m_valid && sif.m_ready) begin
            emitted++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_elem got=%0h exp=none", sif.m_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                assert (sif.m_data === e[W-1:0]) else begin
                    bad++;
                    $error("FAIL stream_data got=%0h exp=%0h", sif.m_data, e[W-1:0]);
                end
                total++;
                assert (sif.m_last === e[W]) else begin
                    bad++;
                    $error("FAIL stream_last got=%0h exp=%0h", sif.m_last, e[W]);
                end
            end
        end
    end

    initial begin
        int e0;
        rst         = 1'b1;
        out_in      = '0;
        sif.m_ready = 1'b0;
        for (int i = 0; i < R; i++) feature_out[i] = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", sif.m_valid, 0);
        chk("rst_data", sif.m_data, 0);
        chk("rst_last", sif.m_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);

        // Aligned capture: latency and back-to-back throughput.
        sif.m_ready = 1'b1;
        cap(4'b1111, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        chk("al_valid_n", sif.m_valid, 0);
        chk("al_busy", busy, 1);
        tick();
        chk("al_valid_n1", sif.m_valid, 1);
        chk("al_data0", sif.m_data, 1);
        e0 = emitted;
        for (int k = 0; k < 4; k++) tick();
        chk("al_count", emitted - e0, 4);
        chk("al_busy_end", busy, 0);

        // Skewed wavefront.
        cap(4'b0001, 8'd10, 8'd0, 8'd0, 8'd0, 1'b0);
        cap(4'b0010, 8'd0, 8'd20, 8'd0, 8'd0, 1'b0);
        cap(4'b0100, 8'd0, 8'd0, 8'd30, 8'd0, 1'b0);
        exp_q.push_back({1'b0, f_stream(8'd10)});
        exp_q.push_back({1'b0, f_stream(8'd20)});
        exp_q.push_back({1'b0, f_stream(8'd30)});
        exp_q.push_back({1'b1, f_stream(8'd40)});
        cap(4'b1000, 8'd0, 8'd0, 8'd0, 8'd40, 1'b0);
        chk("sk_valid_n", sif.m_valid, 0);
        tick();
        chk("sk_valid_n1", sif.m_valid, 1);
        chk("sk_data0", sif.m_data, 10);
        wait_idle(10);

        // Backpressure at idx 2.
        cap(4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
        tick();
        tick();
        tick();
        sif.m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_data", sif.m_data, 30);
            chk("bp_valid", sif.m_valid, 1);
            chk("bp_last", sif.m_last, 0);
            tick();
        end
        sif.m_ready = 1'b1;
        wait_idle(10);

        // Overflow: fifth vector dropped, four emitted in order.
        sif.m_ready = 1'b0;
        for (int v = 0; v < 5; v++) begin
            if (v == 4) chk("ov_before", overflow, 0);
            cap(4'b1111, W'(v*16), W'(v*16+1), W'(v*16+2), W'(v*16+3), v < 4);
        end
        chk("ov_set", overflow, 1);
        e0 = emitted;
        sif.m_ready = 1'b1;
        wait_idle(40);
        chk("ov_count", emitted - e0, 16);
        chk("ov_sticky", overflow, 1);

        // Reset mid-stream at idx 1.
        cap(4'b1111, 8'd5, 8'd6, 8'd7, 8'd8, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mr_valid", sif.m_valid, 0);
        chk("mr_data", sif.m_data, 0);
        chk("mr_last", sif.m_last, 0);
        chk("mr_busy", busy, 0);
        chk("mr_overflow", overflow, 0);
        tick();
        rst = 1'b0;
        e0 = emitted;
        for (int k = 0; k < 6; k++) tick();
        chk("mr_no_elem", emitted - e0, 0);
        chk("mr_valid_after", sif.m_valid, 0);

        // Sign-boundary values (ReLU in the macro build, raw otherwise).
        cap(4'b1111, 8'h05, 8'hFF, 8'h80, 8'h7F, 1'b1);
        tick();
        chk("sg_data0", sif.m_data, 5);
        wait_idle(10);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
